// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SYNC, OPCODE, LEN, payload, CHK.
// Validated frames are held for the core behind a valid/ready handshake.
module uart_rx_frame_ctrl #(
  parameter int          CLOCK_FREQUENCY = 50_000_000,
  parameter int          TIMEOUT_CYCLES  = 500_000,
  parameter int          MAX_LEN         = 16,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  localparam int         LW              = $clog2(MAX_LEN + 1),
  localparam int         AW              = $clog2(MAX_LEN),
  localparam int         TW              = (CLOCK_FREQUENCY > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_done,
  input  logic [7:0]    i_rx_byte,
  output logic          o_cmd_valid,
  input  logic          i_cmd_ready,
  output logic [7:0]    o_cmd_opcode,
  output logic [LW-1:0] o_cmd_len,
  input  logic [AW-1:0] i_pld_addr,
  output logic [7:0]    o_pld_byte,
  output logic          o_busy,
  output logic          o_err_chk,
  output logic          o_err_len,
  output logic          o_err_timeout,
  output logic          o_err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPCODE  = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_r;
  logic            rx_done_q_r;
  logic            valid_r;
  logic [7:0]      opcode_r;
  logic [LW-1:0]   len_r;
  logic [7:0]      chk_r;
  logic [LW-1:0]   cnt_r;
  logic [TW-1:0]   tmo_r;
  logic [7:0]      pld_r;
  logic            err_chk_r;
  logic            err_len_r;
  logic            err_tmo_r;
  logic            err_ovr_r;
  logic [7:0]      ram [0:MAX_LEN-1];

  logic            byte_stb_s;
  logic            in_frame_s;
  logic            tmo_hit_s;
  logic            ram_we_s;
  logic [LW-1:0]   cnt_inc_s;

  assign byte_stb_s = i_rx_done & ~rx_done_q_r;
  assign in_frame_s = (state_r == S_OPCODE) || (state_r == S_LEN) ||
                      (state_r == S_PAYLOAD) || (state_r == S_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit_s  = in_frame_s & ~byte_stb_s & (tmo_r == TMO_LAST);
  assign ram_we_s   = (state_r == S_PAYLOAD) & byte_stb_s;
  assign cnt_inc_s  = cnt_r + LW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_done_q_r <= 1'b0;
    end else begin
      rx_done_q_r <= i_rx_done;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_r <= {TW{1'b0}};
    end else if (!in_frame_s || byte_stb_s || tmo_hit_s) begin
      tmo_r <= {TW{1'b0}};
    end else begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= S_IDLE;
      valid_r   <= 1'b0;
      opcode_r  <= 8'd0;
      len_r     <= {LW{1'b0}};
      chk_r     <= 8'd0;
      cnt_r     <= {LW{1'b0}};
      err_chk_r <= 1'b0;
      err_len_r <= 1'b0;
      err_tmo_r <= 1'b0;
      err_ovr_r <= 1'b0;
    end else begin
      err_chk_r <= 1'b0;
      err_len_r <= 1'b0;
      err_tmo_r <= 1'b0;
      err_ovr_r <= 1'b0;
      if (tmo_hit_s) begin
        err_tmo_r <= 1'b1;
        state_r   <= S_IDLE;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (byte_stb_s && (i_rx_byte == SYNC_BYTE)) state_r <= S_OPCODE;
          end
          S_OPCODE: begin
            if (byte_stb_s) begin
              opcode_r <= i_rx_byte;
              chk_r    <= i_rx_byte;
              state_r  <= S_LEN;
            end
          end
          S_LEN: begin
            if (byte_stb_s) begin
              if (i_rx_byte > MAX_LEN_B) begin
                err_len_r <= 1'b1;
                state_r   <= S_IDLE;
              end else begin
                len_r   <= i_rx_byte[LW-1:0];
                chk_r   <= chk_r ^ i_rx_byte;
                cnt_r   <= {LW{1'b0}};
                state_r <= (i_rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (byte_stb_s) begin
              chk_r <= chk_r ^ i_rx_byte;
              cnt_r <= cnt_inc_s;
              if (cnt_inc_s == len_r) state_r <= S_CHK;
            end
          end
          S_CHK: begin
            if (byte_stb_s) begin
              if (i_rx_byte == chk_r) begin
                valid_r <= 1'b1;
                state_r <= S_HOLD;
              end else begin
                err_chk_r <= 1'b1;
                state_r   <= S_IDLE;
              end
            end
          end
          S_HOLD: begin
            if (byte_stb_s) err_ovr_r <= 1'b1;
            if (valid_r && i_cmd_ready) begin
              valid_r <= 1'b0;
              state_r <= S_IDLE;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  // Payload storage; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (ram_we_s) ram[cnt_r[AW-1:0]] <= i_rx_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pld_r <= 8'd0;
    end else begin
      pld_r <= ram[i_pld_addr];
    end
  end

  assign o_cmd_valid   = valid_r;
  assign o_cmd_opcode  = opcode_r;
  assign o_cmd_len     = len_r;
  assign o_pld_byte    = pld_r;
  assign o_busy        = in_frame_s;
  assign o_err_chk     = err_chk_r;
  assign o_err_len     = err_len_r;
  assign o_err_timeout = err_tmo_r;
  assign o_err_overrun = err_ovr_r;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller placed directly after the UART receiver. It assembles received bytes into coprocessor command frames of the form SYNC, OPCODE, LEN, LEN payload bytes, then CHK. It checks each frame for integrity, buffers the payload, and presents a validated command to the coprocessor core through a valid/ready handshake. Malformed, oversized and stalled frames are dropped and reported through one-cycle error strobes.

Parameters:
CLOCK_FREQUENCY, 50_000_000, system clock in Hz; used only to document the timeout.
TIMEOUT_CYCLES, 500_000, maximum idle gap between bytes inside a frame, in i_clk cycles (10 ms at default clock).
MAX_LEN, 16, payload buffer depth in bytes; legal LEN range is 0..MAX_LEN.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
i_clk  input  1  system clock; all logic is on its rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_rx_done  input  1  byte-complete indication from the UART receiver; may be high for one or more cycles.
i_rx_byte  input  8  received byte; stable while i_rx_done is high.
o_cmd_valid  output  1  validated command is available.
i_cmd_ready  input  1  core accepts the command.
o_cmd_opcode  output  8  command opcode.
o_cmd_len  output  $clog2(MAX_LEN+1)  payload length.
i_pld_addr  input  $clog2(MAX_LEN)  payload read index.
o_pld_byte  output  8  payload byte at i_pld_addr, registered (1-cycle read latency).
o_busy  output  1  controller is inside a frame (any state other than IDLE and HOLD).
o_err_chk  output  1  one-cycle strobe: checksum mismatch.
o_err_len  output  1  one-cycle strobe: LEN > MAX_LEN.
o_err_timeout  output  1  one-cycle strobe: inter-byte timeout.
o_err_overrun  output  1  one-cycle strobe: byte arrived while in HOLD and was discarded.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert is handled by the top level):
  - State goes to IDLE.
  - All outputs go to 0, including o_cmd_opcode, o_cmd_len and o_pld_byte.
  - Checksum register, byte counter, timeout counter and rx_done edge register clear.
  - Payload RAM contents are don't-care.
- Byte strobe:
  - rx_done_q is a registered copy of i_rx_done.
  - byte_stb = i_rx_done & ~rx_done_q.
  - Exactly one byte is consumed per rising edge of i_rx_done, regardless of pulse width.
- States:
  - IDLE: on byte_stb with byte == SYNC_BYTE -> OPCODE. Any other byte is silently ignored.
  - OPCODE: on byte_stb, latch opcode, chk <= byte, go to LEN.
  - LEN: on byte_stb:
    - If byte > MAX_LEN: pulse o_err_len, go to IDLE.
    - Otherwise: latch len, chk <= chk ^ byte, cnt <= 0. Go to CHK if byte == 0, else PAYLOAD.
  - PAYLOAD: on byte_stb, ram[cnt] <= byte, chk <= chk ^ byte, cnt <= cnt + 1. When cnt == len-1, go to CHK.
  - CHK: on byte_stb:
    - If byte == chk: o_cmd_valid <= 1, go to HOLD.
    - Otherwise: pulse o_err_chk, go to IDLE.
  - HOLD:
    - o_cmd_valid stays high; opcode, len and payload RAM are frozen.
    - When o_cmd_valid & i_cmd_ready are both high in a cycle, o_cmd_valid <= 0 on the next edge and the state goes to IDLE.
    - Any byte_stb in HOLD is discarded and pulses o_err_overrun. This applies even when i_cmd_ready is high in the same cycle.
- Timeout:
  - Counter runs in OPCODE, LEN, PAYLOAD and CHK.
  - It is cleared on every byte_stb and on entry from IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_stb: pulse o_err_timeout, go to IDLE.
  - If byte_stb and timeout expiry happen in the same cycle, the byte wins and no error is raised.
  - Counter is held at 0 in IDLE and HOLD.
- Error strobes: exactly 1 cycle wide and mutually exclusive.
- Payload read:
  - o_pld_byte <= ram[i_pld_addr] every cycle, in any state.
  - Reads at addresses >= len return stale data; this is legal but the value is undefined.
- Checksum arithmetic: 8-bit XOR of OPCODE, LEN and all payload bytes. SYNC_BYTE is excluded.
- Counter width: cnt is $clog2(MAX_LEN+1) bits and never wraps, because LEN is bounded by MAX_LEN.
- Latency: o_cmd_valid rises 1 cycle after the byte_stb of the CHK byte.

Test Plan:
- Good frame: A5,03,02,11,22,(03^02^11^22=0x32) -> o_cmd_valid=1, opcode=0x03, len=2; pld[0]=0x11 and pld[1]=0x22 with 1-cycle read latency; valid drops the cycle after i_cmd_ready=1.
- Zero-length frame and pulse width: A5,07,00,07 with i_rx_done held high 5 cycles per byte -> single command, opcode 0x07, len 0; no duplicate bytes consumed.
- Checksum and length errors: A5,03,01,55,00 -> o_err_chk one cycle, no valid. Then A5,01,11 (17 > MAX_LEN) -> o_err_len, state IDLE; a following good frame is accepted.
- Timeout: A5,03 followed by TIMEOUT_CYCLES of silence -> o_err_timeout pulse at exactly that cycle count, o_busy=0. Gap of TIMEOUT_CYCLES-1 followed by a byte -> no error.
- Overrun: good frame, i_cmd_ready held 0, then 3 more bytes -> 3 o_err_overrun pulses; opcode, len and payload unchanged.
- Async reset asserted mid-PAYLOAD -> all outputs 0 immediately without a clock edge; after release, a garbage byte followed by a fresh good frame -> only the fresh frame is accepted.
